// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, PC width and the fetch state type.
package cpu_pkg;

    localparam int PC_W = 10;

    localparam logic [5:0] OP_JMP = 6'b010101;
    localparam logic [5:0] OP_JAL = 6'b010110;
    localparam logic [5:0] OP_JST = 6'b010111;
    localparam logic [5:0] OP_HLT = 6'b010010;
    localparam logic [5:0] OP_BEQ = 6'b010011;
    localparam logic [5:0] OP_BNE = 6'b010100;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and redirect path.
interface instr_fetch_if #(
    parameter int PC_W = cpu_pkg::PC_W
);
    import cpu_pkg::*;

    logic [PC_W-1:0] mem_addr;
    logic [31:0]     mem_rdata;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    // Fetch side: drives the memory address and the instruction to decode.
    modport master (
        output mem_addr, instr, instr_pc, instr_valid, halted,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );

    // Memory/decode side.
    modport slave (
        input  mem_addr, instr, instr_pc, instr_valid, halted,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_predecode.sv
// Combinational pre-decode of the word returned by instruction memory:
// resolves jmp/jal targets and hlt locally so they cost no bubbles.
module fetch_predecode #(
    parameter int PC_W = cpu_pkg::PC_W
) (
    input  logic [31:0]     mem_rdata,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            is_jump,
    output logic            is_halt,
    output logic [PC_W-1:0] next_pc
);
    import cpu_pkg::*;

    logic [5:0] opcode;
    logic       target_hi_unused;

    assign opcode = mem_rdata[31:26];

    // Target bits above the PC width are dropped; keep them visibly consumed.
    assign target_hi_unused = ^mem_rdata[25:PC_W];

    // Next fetch address: jump target, hold on halt, else sequential (wraps).
    always_comb begin
        is_jump = (opcode == OP_JMP) || (opcode == OP_JAL);
        is_halt = (opcode == OP_HLT);
        next_pc = fetch_pc + 1'b1;
        if (is_jump) begin
            next_pc = mem_rdata[PC_W-1:0];
        end else if (is_halt) begin
            next_pc = fetch_pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, captures the memory word into the
// instruction register and hands it to decode with valid/ready.
module instr_fetch #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);
    import cpu_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_nxt;

    logic [PC_W-1:0] fetch_pc_p0;
    logic [31:0]     instr_p1;
    logic [PC_W-1:0] instr_pc_p1;
    logic            vld_p1;

    logic            load;
    logic            take_redirect;
    logic            is_halt;
    logic            is_jump_unused;
    logic [PC_W-1:0] next_pc;

    fetch_predecode #(.PC_W(PC_W)) u_predecode (
        .mem_rdata (bus.mem_rdata),
        .fetch_pc  (fetch_pc_p0),
        .is_jump   (is_jump_unused),
        .is_halt   (is_halt),
        .next_pc   (next_pc)
    );

    // Redirect is meaningless before the first memory read has completed.
    assign take_redirect = bus.redirect && (state != START);

    // Capture a new word when the register is empty or being drained.
    assign load = (state == FETCH) && !bus.redirect && (!vld_p1 || bus.instr_ready);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a fetched hlt parks the FSM until a redirect.
    always_comb begin
        state_nxt = state;
        case (state)
            START:   state_nxt = FETCH;
            FETCH:   if (load && is_halt) state_nxt = HALT;
            HALT:    if (bus.redirect) state_nxt = FETCH;
            default: state_nxt = START;
        endcase
    end

    // ---- stage p0 -> p1: PC update and instruction capture ----
    // Redirect squashes the held word; load captures; a bare accept empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_p0 <= RESET_PC;
            instr_p1    <= '0;
            instr_pc_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (take_redirect) begin
            fetch_pc_p0 <= bus.redirect_pc;
            vld_p1      <= 1'b0;
        end else if (load) begin
            instr_p1    <= bus.mem_rdata;
            instr_pc_p1 <= fetch_pc_p0;
            vld_p1      <= 1'b1;
            fetch_pc_p0 <= next_pc;
        end else if (vld_p1 && bus.instr_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign bus.mem_addr    = fetch_pc_p0;
    assign bus.instr       = instr_p1;
    assign bus.instr_pc    = instr_pc_p1;
    assign bus.instr_valid = vld_p1;
    assign bus.halted      = (state == HALT) && !vld_p1;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle-memory processor. It owns the program counter and drives the instruction memory address. It captures the 32-bit word the memory returns and presents it to decode with a valid/ready handshake. Unconditional `jmp`/`jal` and `hlt` are pre-decoded locally; branches and `jst` are resolved downstream and arrive as a redirect.

## Interface
Parameters:
- `PC_W`, 10 — PC / memory address width.
- `RESET_PC`, 0 — PC value loaded on reset.

Ports:
- `clk` in 1 — single clock, rising-edge. The instruction memory samples on the falling edge of this same clock.
- `reset` in 1 — synchronous, active-high.
- `mem_addr` out PC_W — instruction memory address; always equals `fetch_pc`.
- `mem_rdata` in 32 — memory read data. At each rising edge it equals `ram[mem_addr]` as driven during the preceding cycle.
- `instr` out 32 — instruction word presented to decode.
- `instr_pc` out PC_W — address `instr` was fetched from.
- `instr_valid` out 1 — `instr`/`instr_pc` hold a live instruction.
- `instr_ready` in 1 — decode accepts `instr` this cycle.
- `redirect` in 1 — downstream redirect (taken `beq`/`bne`, `jst`).
- `redirect_pc` in PC_W — redirect target.
- `halted` out 1 — `hlt` has been fetched and accepted by decode; fetch is stopped.

## Operation
- State machine: `START`, `FETCH`, `HALT`.
- Reset values: state `START`, `fetch_pc = RESET_PC`, `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `halted = 0`.
- `START` goes to `FETCH` after one cycle. This guarantees one full memory read of `RESET_PC` before the first capture.
- Load condition: state `FETCH` && !`redirect` && (!`instr_valid` || `instr_ready`).
- On load:
  - `instr <= mem_rdata`, `instr_pc <= fetch_pc`, `instr_valid <= 1`.
  - `fetch_pc` updates by opcode `mem_rdata[31:26]`:
    - `jmp` (`010101`) or `jal` (`010110`): `mem_rdata[PC_W-1:0]`. Upper target bits are truncated.
    - `hlt` (`010010`): hold, and the state goes to `HALT`.
    - Otherwise: `fetch_pc + 1`, wrapping mod 2^PC_W (1023 → 0).
- Accept without load (e.g. in `HALT`): `instr_valid <= 0`.
- Stall (`instr_valid` && !`instr_ready`): `instr`, `instr_pc`, `fetch_pc` all hold. Because `mem_addr` is unchanged, the memory keeps re-reading the same word, so no data is lost.
- `redirect` has priority over load, stall and `HALT`:
  - `instr_valid <= 0`, which squashes the held instruction.
  - `fetch_pc <= redirect_pc`; state goes to `FETCH`; `halted <= 0`.
  - `redirect` is ignored in `START` and while `reset` is asserted.
- `halted` is 1 when state is `HALT` and `instr_valid = 0`, i.e. the `hlt` has been consumed. It is cleared only by reset or redirect.
- `jal` link value is `instr_pc + 1`; decode computes it. This block outputs no link value.

## Timing
- Capture latency: the address is driven at edge k and the word is captured at edge k+1. Throughput is one instruction per cycle while `instr_ready = 1`.
- Pre-decoded `jmp`/`jal`: zero bubbles; the target word is captured on the next edge.
- Redirect: exactly one bubble. `redirect` is seen at edge k, `instr_valid = 0` during cycle k, and the target is valid after edge k+1.
- Reset: first `instr_valid` rises at the 2nd rising edge after reset deasserts (the `START` edge plus the first load).
- Reset mid-stall or mid-halt clears everything on the next edge; no partial state survives.
- Simultaneous `redirect` and `instr_ready`: the accept has no effect and the redirect wins.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_JMP`, `OP_JAL`, `OP_JST`, `OP_HLT`, `OP_BEQ`, `OP_BNE`;
  - `PC_W`;
  - the fetch state enum.
- Sub-module `fetch_predecode` (combinational) takes `mem_rdata` and `fetch_pc`. It outputs `is_jump`, `is_halt` and `next_pc`.
- The remainder is the state register, PC/IR registers and load/stall/redirect control.

## Test plan
- Straight-line run: ram[0..3] hold `addi` words, `instr_ready = 1`. After reset release, `instr_pc` is 0, 1, 2, 3 on consecutive cycles starting at the 2nd edge, and `instr` matches ram.
- Pre-decoded jump: ram[1] = `jmp 27`. `instr_pc` sequence is 0, 1, 27, 28 with no gap and no instr_pc 2.
- Stall: `instr_ready = 0` for 3 cycles while `instr_pc = 5`. `instr`, `instr_pc`, `mem_addr = 6` are held. On release, `instr_pc` 6 follows on the next edge.
- Redirect: `redirect = 1`, `redirect_pc = 11` while `instr_pc = 7` is valid and unaccepted. Next cycle `instr_valid = 0`; the cycle after, `instr_pc = 11`.
- Halt: ram[45] = `hlt`, reached via `jmp 45`. `hlt` is presented once; after acceptance `halted = 1` and `instr_valid = 0` indefinitely. A subsequent `redirect` to 2 resumes at `instr_pc = 2`, and `reset` returns the block to PC 0.
- Wrap: `redirect_pc = 1023` with a non-jump word there; the following `instr_pc` is 0.
